accel_spi_sequencer: RTL

- Hardware SPI master that initialises and periodically polls the on-board ADXL345 accelerometer.
- Presents signed X/Y/Z samples to the game logic without involving the Nios.
- Arbitrates the single physical SPI bus between itself and the SoC spi0 master (host), so the host SPI path is only ever granted between sequencer transactions.

---
 rtl/accel_spi_sequencer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/accel_spi_sequencer.sv
// SPI master that configures and polls an ADXL345, presenting X/Y/Z samples,
// and shares the physical SPI bus with the SoC spi0 master between transactions.
module accel_spi_sequencer #(
  parameter int unsigned CLK_DIV     = 25,
  parameter int unsigned POLL_CYCLES = 500000,
  parameter int unsigned CS_GAP      = 10
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        host_req,
  output logic        host_gnt,
  input  logic        host_sclk,
  input  logic        host_mosi,
  input  logic        host_ss_n,
  output logic        host_miso,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_ss_n,
  input  logic        spi_miso,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        accel_valid,
  output logic        init_done,
  output logic        busy
);

  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned GAP_W   = $clog2(CS_GAP) + 1;
  localparam int unsigned POLL_W  = $clog2(POLL_CYCLES) + 1;
  localparam int unsigned HALF_W  = 7;
  localparam int unsigned SR_W    = 56;
  localparam int unsigned RX_W    = 48;
  localparam int unsigned WR_LAST = 2 * 16 + 1;
  localparam int unsigned RD_LAST = 2 * 56 + 1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_INIT_XFER,
    ST_INIT_GAP,
    ST_WAIT,
    ST_READ_XFER,
    ST_READ_GAP,
    ST_HOST
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [1:0]          wr_idx_q, wr_idx_d;
  logic [SR_W-1:0]     tx_sr_q, tx_sr_d;
  logic [RX_W-1:0]     rx_sr_q, rx_sr_d;
  logic [POLL_W-1:0]   timer_q, timer_d;
  logic                pending_q, pending_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                ss_n_q, ss_n_d;
  logic [15:0]         accel_x_q, accel_x_d;
  logic [15:0]         accel_y_q, accel_y_d;
  logic [15:0]         accel_z_q, accel_z_d;
  logic                valid_q, valid_d;
  logic                init_done_q, init_done_d;
  logic                host_gnt_q, host_gnt_d;
  logic                busy_q, busy_d;

  logic                xfer_q, xfer_d;
  logic                div_wrap, gap_end, poll_wrap;
  logic                sclk_fall, miso_take, start_read, latch;
  logic [HALF_W-1:0]   half_last;

  // Configuration writes: register address then value.
  function automatic logic [15:0] write_word(input logic [1:0] idx);
    case (idx)
      2'd0:    write_word = 16'h310B;
      2'd1:    write_word = 16'h2C0A;
      default: write_word = 16'h2D08;
    endcase
  endfunction

  // Half-period 0 is the lead-in, odd halves below half_last are SCLK low, half_last is the tail.
  assign xfer_q    = (state_q == ST_INIT_XFER) || (state_q == ST_READ_XFER);
  assign half_last = (state_q == ST_READ_XFER) ? HALF_W'(RD_LAST) : HALF_W'(WR_LAST);
  assign div_wrap  = (div_q == DIV_W'(CLK_DIV - 1));
  assign gap_end   = (gap_q == GAP_W'(CS_GAP - 1));
  assign poll_wrap = init_done_q && (timer_q == POLL_W'(POLL_CYCLES - 1));
  assign sclk_fall = xfer_q && div_wrap && !half_q[0] && (half_q < (half_last - HALF_W'(1)));
  assign miso_take = xfer_q && (div_q == '0) && !half_q[0] && (half_q != '0);
  assign latch     = (state_q == ST_READ_GAP) && (gap_q == '0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_INIT;
      div_q       <= '0;
      half_q      <= '0;
      gap_q       <= '0;
      wr_idx_q    <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      timer_q     <= '0;
      pending_q   <= 1'b0;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      accel_x_q   <= '0;
      accel_y_q   <= '0;
      accel_z_q   <= '0;
      valid_q     <= 1'b0;
      init_done_q <= 1'b0;
      host_gnt_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      half_q      <= half_d;
      gap_q       <= gap_d;
      wr_idx_q    <= wr_idx_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ss_n_q      <= ss_n_d;
      accel_x_q   <= accel_x_d;
      accel_y_q   <= accel_y_d;
      accel_z_q   <= accel_z_d;
      valid_q     <= valid_d;
      init_done_q <= init_done_d;
      host_gnt_q  <= host_gnt_d;
      busy_q      <= busy_d;
    end
  end

  // Next state, bit timing, shift registers and poll timer.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    gap_d      = gap_q;
    wr_idx_d   = wr_idx_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    start_read = 1'b0;

    case (state_q)
      ST_INIT: begin
        state_d  = ST_INIT_XFER;
        div_d    = '0;
        half_d   = '0;
        wr_idx_d = '0;
        tx_sr_d  = {write_word(2'd0), 40'd0};
      end
      ST_INIT_XFER, ST_READ_XFER: begin
        div_d = div_wrap ? '0 : div_q + DIV_W'(1);
        if (div_wrap) begin
          if (half_q == half_last) begin
            half_d  = '0;
            gap_d   = '0;
            state_d = (state_q == ST_READ_XFER) ? ST_READ_GAP : ST_INIT_GAP;
          end else begin
            half_d = half_q + HALF_W'(1);
          end
        end
        if (sclk_fall) tx_sr_d = {tx_sr_q[SR_W-2:0], 1'b0};
        if (miso_take) rx_sr_d = {rx_sr_q[RX_W-2:0], spi_miso};
      end
      ST_INIT_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_end) begin
          if (wr_idx_q == 2'd2) begin
            state_d = ST_WAIT;
          end else begin
            state_d  = ST_INIT_XFER;
            wr_idx_d = wr_idx_q + 2'd1;
            div_d    = '0;
            half_d   = '0;
            tx_sr_d  = {write_word(wr_idx_q + 2'd1), 40'd0};
          end
        end
      end
      ST_READ_GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_end) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A pending read beats a simultaneous host request.
        if (pending_q) begin
          state_d    = ST_READ_XFER;
          start_read = 1'b1;
          div_d      = '0;
          half_d     = '0;
          tx_sr_d    = {8'hF2, 48'd0};
        end else if (host_req && init_done_q) begin
          state_d = ST_HOST;
        end
      end
      ST_HOST: begin
        if (!host_req) state_d = ST_WAIT;
      end
      default: state_d = ST_INIT;
    endcase

    if (init_done_q) begin
      timer_d   = poll_wrap ? '0 : timer_q + POLL_W'(1);
      pending_d = poll_wrap || (pending_q && !start_read);
    end else begin
      timer_d   = '0;
      pending_d = 1'b0;
    end
  end

  // Registered outputs derived from the next state so they line up with state_q.
  always_comb begin
    xfer_d      = (state_d == ST_INIT_XFER) || (state_d == ST_READ_XFER);
    ss_n_d      = !xfer_d;
    sclk_d      = !(xfer_d && half_d[0] && (half_d != half_last));
    mosi_d      = sclk_fall ? tx_sr_q[SR_W-1] : (xfer_d ? mosi_q : 1'b0);
    busy_d      = xfer_d || (state_d == ST_INIT_GAP) || (state_d == ST_READ_GAP);
    host_gnt_d  = (state_d == ST_HOST);
    init_done_d = init_done_q || ((state_q == ST_INIT_GAP) && (state_d == ST_WAIT));
    valid_d     = latch;
    accel_x_d   = accel_x_q;
    accel_y_d   = accel_y_q;
    accel_z_d   = accel_z_q;
    if (latch) begin
      accel_x_d = {rx_sr_q[39:32], rx_sr_q[47:40]};
      accel_y_d = {rx_sr_q[23:16], rx_sr_q[31:24]};
      accel_z_d = {rx_sr_q[7:0],   rx_sr_q[15:8]};
    end
  end

  assign spi_sclk    = host_gnt_q ? host_sclk : sclk_q;
  assign spi_mosi    = host_gnt_q ? host_mosi : mosi_q;
  assign spi_ss_n    = host_gnt_q ? host_ss_n : ss_n_q;
  assign host_miso   = spi_miso;
  assign host_gnt    = host_gnt_q;
  assign accel_x     = accel_x_q;
  assign accel_y     = accel_y_q;
  assign accel_z     = accel_z_q;
  assign accel_valid = valid_q;
  assign init_done   = init_done_q;
  assign busy        = busy_q;

endmodule
